// File: rtl/instruction_fetch_queue.sv
// Decoupled instruction-fetch front end: sequential word fetches into a
// DEPTH-entry prefetch FIFO, valid/ready hand-off to decode, redirect flush.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        inst_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic          run_q, run_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_base;

  // Credit covers both buffered and in-flight fetches so a push never overflows.
  assign credit_ok      = (SW'(count_q) + SW'(outst_q)) < SW'(DEPTH);
  assign imem_req_valid = run_q && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid     = (count_q != '0);
  assign inst_data      = fifo_data_q[rd_ptr_q];
  assign inst_pc        = fifo_pc_q[rd_ptr_q];
  assign inst_pc_plus4  = inst_pc + 32'd4;
  assign pop            = inst_valid && inst_ready;

  assign push           = imem_resp_valid && !redirect_valid && (drop_q == '0);
  assign redirect_base  = redirect_pc & ~32'h0000_0003;

  // Next-state: redirect overrides all other bookkeeping in its cycle.
  always_comb begin
    run_d      = 1'b1;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      outst_d    = outst_q - CW'(imem_resp_valid);
      drop_d     = outst_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      run_q      <= run_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is reset so the head fields read zero while the queue is in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: pipelined memory model with
// configurable latency/stalls, transfer collector and hand-computed checks.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        inst_ready = 1'b0;

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4),
    .inst_ready      (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] p4;
    int          cyc;
  } xfer_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int mem_lat = 1;
  bit mem_toggle = 1'b0;
  xfer_t got[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: accepts at edge k, response visible for sampling at edge k+L.
  initial begin
    bit          fire_s;
    logic [31:0] addr_s;
    bit          prev_stall;
    logic [31:0] prev_addr;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    forever begin
      @(negedge clk);
      fire_s = rst_n && imem_req_valid && imem_req_ready;
      addr_s = imem_req_addr;
      if (prev_stall && rst_n && !redirect_valid) begin
        check_eq("req_hold_valid", 32'(imem_req_valid), 32'd1);
        check_eq("req_hold_addr", imem_req_addr, prev_addr);
      end
      prev_stall = rst_n && imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr  = imem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        mq_addr.delete();
        mq_due.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end else begin
        if (fire_s) begin
          mq_addr.push_back(addr_s);
          mq_due.push_back(cyc + mem_lat - 1);
          n_acc++;
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = ifn(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = 32'h0;
        end
      end
      imem_req_ready = mem_toggle ? ((cyc % 2) == 1) : 1'b1;
    end
  end

  // Collect every consumer transfer.
  initial begin
    forever begin
      xfer_t x;
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready) begin
        x.pc = inst_pc; x.data = inst_data; x.p4 = inst_pc_plus4; x.cyc = cyc;
        got.push_back(x);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat, input bit rdy, input bit tog, output int cr);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = rdy;
    mem_lat = lat;
    mem_toggle = tog;
    step();
    step();
    rst_n = 1'b1;
    cr = cyc;
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 200) begin
      step();
      k++;
    end
    if (got.size() < n) check_eq({tag, "_timeout"}, 32'(got.size()), 32'(n));
  endtask

  task automatic redirect_to(input logic [31:0] pc, output int base);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    #1;
    check_eq("redir_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    base = got.size();
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int base, input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] epc;
      epc = pc0 + 32'(4 * i);
      check_eq({tag, "_pc"}, got[base + i].pc, epc);
      check_eq({tag, "_data"}, got[base + i].data, ifn(epc));
      check_eq({tag, "_pc4"}, got[base + i].p4, epc + 32'd4);
    end
  endtask

  initial begin
    int cr;
    int base;
    int acc0;

    // Reset values and L=1 streaming.
    inst_ready = 1'b1;
    step();
    step();
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst_data", inst_data, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_inst_pc4", inst_pc_plus4, 32'h4);
    base = got.size();
    rst_n = 1'b1;
    cr = cyc;
    #1;
    check_eq("run_gap_req", 32'(imem_req_valid), 32'd0);
    step();
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_req_addr, 32'h0);
    wait_got(base + 8, "stream");
    check_seq("stream", base, 32'h0, 8);
    check_eq("stream_first_cyc", 32'(got[base].cyc - cr), 32'd3);
    for (int i = 1; i < 8; i++)
      check_eq("stream_b2b", 32'(got[base + i].cyc - got[base].cyc), 32'(i));

    // Back-pressure: only DEPTH fetches accepted, then no loss on release.
    do_reset(1, 1'b0, 1'b0, cr);
    acc0 = n_acc;
    repeat (12) step();
    check_eq("bp_accepted", 32'(n_acc - acc0), 32'd4);
    check_eq("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("bp_inst_valid", 32'(inst_valid), 32'd1);
    base = got.size();
    inst_ready = 1'b1;
    wait_got(base + 8, "bp");
    check_seq("bp", base, 32'h0, 8);

    // Redirect with three outstanding and a response landing that cycle.
    do_reset(3, 1'b1, 1'b0, cr);
    begin
      int k = 0;
      while (!(imem_resp_valid && mq_addr.size() == 2) && k < 20) begin
        step();
        k++;
      end
    end
    check_eq("l3_redir_cyc", 32'(cyc - cr), 32'd4);
    base = got.size();
    check_eq("l3_no_early_xfer", 32'(base), 32'(got.size()));
    redirect_to(32'h100, base);
    check_eq("l3_flush_valid", 32'(inst_valid), 32'd0);
    wait_got(base + 3, "l3");
    check_seq("l3", base, 32'h100, 3);

    // Pop of head 0x8 in the redirect cycle is kept; flush then 0x40.
    do_reset(1, 1'b0, 1'b0, cr);
    repeat (10) step();
    base = got.size();
    inst_ready = 1'b1;
    step();
    step();
    redirect_to(32'h40, acc0);
    check_eq("rp_c3_valid", 32'(inst_valid), 32'd0);
    step();
    check_eq("rp_c4_valid", 32'(inst_valid), 32'd0);
    step();
    check_eq("rp_c5_valid", 32'(inst_valid), 32'd1);
    check_eq("rp_c5_pc", inst_pc, 32'h40);
    wait_got(base + 5, "rp");
    check_seq("rp_old", base, 32'h0, 3);
    check_seq("rp_new", base + 3, 32'h40, 2);

    // Wrap-around and request stalls; low address bits of redirect ignored.
    do_reset(1, 1'b1, 1'b1, cr);
    repeat (6) step();
    redirect_to(32'hFFFF_FFFC, base);
    wait_got(base + 3, "wrap");
    check_eq("wrap_pc0", got[base].pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", got[base].p4, 32'h0);
    check_eq("wrap_data0", got[base].data, ifn(32'hFFFF_FFFC));
    check_seq("wrap_tail", base + 1, 32'h0, 2);
    redirect_to(32'h103, base);
    wait_got(base + 2, "align");
    check_seq("align", base, 32'h100, 2);
    mem_toggle = 1'b0;

    // Async reset with count=3, outstanding=1 clears outputs without an edge.
    do_reset(1, 1'b0, 1'b0, cr);
    repeat (5) step();
    check_eq("ar_pre_valid", 32'(inst_valid), 32'd1);
    check_eq("ar_pre_req", 32'(imem_req_valid), 32'd0);
    check_eq("ar_pre_resp", 32'(imem_resp_valid), 32'd1);
    check_eq("ar_pre_addr", imem_req_addr, 32'h10);
    rst_n = 1'b0;
    #1;
    check_eq("ar_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("ar_inst_data", inst_data, 32'h0);
    check_eq("ar_inst_pc", inst_pc, 32'h0);
    check_eq("ar_inst_pc4", inst_pc_plus4, 32'h4);
    check_eq("ar_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("ar_req_addr", imem_req_addr, 32'h0);
    do_reset(1, 1'b1, 1'b0, cr);
    base = got.size();
    wait_got(base + 3, "ar");
    check_seq("ar", base, 32'h0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
